board_store: RTL

//  Parametrised N x N game-board store. It replaces the fixed 3x3 memArray.
//  It accepts cell writes over a valid/ready handshake and enforces write-once

---
 rtl/board_store.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/board_store.sv
// board_store: N x N write-once game board with a sequential line scanner.
// Define BOARD_UNDO_EN to add a one-level undo input.
module board_store #(
    parameter  int N      = 3,
    localparam int CELLS  = N * N,
    localparam int ADDR_W = $clog2(CELLS),
    localparam int LINES  = 2 * N + 2,
    localparam int CNT_W  = $clog2(CELLS + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
`ifdef BOARD_UNDO_EN
    input  logic               undo,
`endif
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [1:0]         wr_cell,
    output logic               wr_ack,
    output logic               wr_err,
    output logic [2*CELLS-1:0] gBoard,
    output logic [CNT_W-1:0]   moves,
    output logic               result_valid,
    output logic [1:0]         winner,
    output logic               draw
);

    localparam int LW = $clog2(LINES);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           state, state_nxt;
    logic [1:0]       cells [CELLS];
    logic [LW-1:0]    line;
    logic             scan_v, hit_q, last_q, found;
    logic [1:0]       hit_cell, found_cell, lead;
    logic             line_hit, locked, xfer, write_go;
    logic             addr_bad, bad, scan_end, undo_pri;
`ifdef BOARD_UNDO_EN
    logic [ADDR_W-1:0] last_addr;
    logic              last_ok;
`endif

    // Line l: rows first, then columns, main diagonal, anti-diagonal.
    function automatic logic [ADDR_W-1:0] cell_idx(input logic [LW-1:0] l, input int j);
        int li;
        int r;
        li = int'(l);
        if (li < N)
            r = li * N + j;
        else if (li < 2 * N)
            r = j * N + (li - N);
        else if (li == 2 * N)
            r = j * N + j;
        else
            r = j * N + (N - 1 - j);
        return ADDR_W'(r);
    endfunction

    always_comb begin
        gBoard = '0;
        for (int i = 0; i < CELLS; i++)
            gBoard[2*i +: 2] = cells[i];
    end

    always_comb begin
        lead     = cells[cell_idx(line, 0)];
        line_hit = (lead == 2'b01) || (lead == 2'b10);
        for (int j = 1; j < N; j++)
            if (cells[cell_idx(line, j)] != lead)
                line_hit = 1'b0;
    end

`ifdef BOARD_UNDO_EN
    assign undo_pri = undo;
`else
    assign undo_pri = 1'b0;
`endif

    assign locked   = (winner != 2'b00) || draw;
    assign wr_ready = (state == IDLE) && !locked;
    assign xfer     = wr_valid && wr_ready;
    assign write_go = xfer && !undo_pri;
    assign addr_bad = int'(wr_addr) >= CELLS;
    assign bad      = addr_bad || (wr_cell == 2'b00) || (wr_cell == 2'b11)
                   || (!addr_bad && (cells[wr_addr] != 2'b00));
    // Line hits are registered, so the decision trails the scan by one cycle.
    assign scan_end = scan_v && (hit_q || last_q);

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (write_go && !bad) state_nxt = SCAN;
            SCAN:    if (scan_end) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset || clear)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        wr_ack <= 1'b0;
        wr_err <= 1'b0;
        if (!reset || clear) begin
            cells        <= '{default: 2'b00};
            moves        <= '0;
            winner       <= 2'b00;
            draw         <= 1'b0;
            result_valid <= 1'b0;
            line         <= '0;
            scan_v       <= 1'b0;
            hit_q        <= 1'b0;
            last_q       <= 1'b0;
            hit_cell     <= 2'b00;
            found        <= 1'b0;
            found_cell   <= 2'b00;
`ifdef BOARD_UNDO_EN
            last_addr    <= '0;
            last_ok      <= 1'b0;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    result_valid <= 1'b1;
`ifdef BOARD_UNDO_EN
                    if (undo) begin
                        if (last_ok && (moves != '0)) begin
                            cells[last_addr] <= 2'b00;
                            moves   <= moves - CNT_W'(1);
                            winner  <= 2'b00;
                            draw    <= 1'b0;
                            last_ok <= 1'b0;
                            wr_ack  <= 1'b1;
                        end else begin
                            wr_err <= 1'b1;
                        end
                    end else
`endif
                    if (xfer) begin
                        if (bad) begin
                            wr_err <= 1'b1;
                        end else begin
                            cells[wr_addr] <= wr_cell;
                            if (moves != CNT_W'(CELLS))
                                moves <= moves + CNT_W'(1);
                            wr_ack       <= 1'b1;
                            result_valid <= 1'b0;
                            line         <= '0;
                            scan_v       <= 1'b0;
                            hit_q        <= 1'b0;
                            last_q       <= 1'b0;
`ifdef BOARD_UNDO_EN
                            last_addr    <= wr_addr;
                            last_ok      <= 1'b1;
`endif
                        end
                    end
                end
                SCAN: begin
                    hit_q    <= line_hit;
                    hit_cell <= lead;
                    last_q   <= (line == LW'(LINES - 1));
                    line     <= line + LW'(1);
                    scan_v   <= 1'b1;
                    if (scan_end) begin
                        found      <= hit_q;
                        found_cell <= hit_cell;
                    end
                end
                DONE: begin
                    winner       <= found ? found_cell : 2'b00;
                    draw         <= !found && (moves == CNT_W'(CELLS));
                    result_valid <= 1'b1;
                end
                default: ;
            endcase
`ifdef BOARD_UNDO_EN
            if (undo && (state != IDLE))
                wr_err <= 1'b1;
`endif
        end
    end

endmodule
